goertzel_tone_gen: RTL and testbench

Recursive sinusoidal tone generator; the transmit-side counterpart of the Goertzel detector chain. It runs the Goertzel resonator recursion with no input: s[n] = c·s[n-1] − s[n-2], seeded with one nonzero state. This yields a bounded sinusoid of programmed frequency for a programmed number of samples. It drives DTMF and test tones into the detector path and into loopback benches.

---
 rtl/goertzel_pkg.sv | 28 ++
 rtl/goertzel_tone_gen_mac.sv | 44 ++++
 rtl/goertzel_tone_gen.sv | 105 ++++++++++
 tb/tb_goertzel_tone_gen.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/goertzel_pkg.sv
// rtl/goertzel_pkg.sv - shared Goertzel types, state encoding, Q-format and saturation limits
package goertzel_pkg;

    localparam int GTG_W   = 24;
    localparam int GTG_C_W = 18;
    localparam int GTG_L_W = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        GTG_IDLE = ST_IDLE,
        GTG_RUN  = ST_RUN,
        GTG_DONE = ST_DONE
    } gtg_state_e;

    // Coefficients are 2*cos(w) in Q2.(C_W-2): two integer bits cover [-2, 2).
    localparam int GTG_Q_FRAC = GTG_C_W - 2;

    localparam logic signed [GTG_W-1:0] W_MAX = {1'b0, {(GTG_W-1){1'b1}}};
    localparam logic signed [GTG_W-1:0] W_MIN = {1'b1, {(GTG_W-1){1'b0}}};

    function automatic int q_frac(input int c_w);
        return c_w - 2;
    endfunction

endpackage

// File: rtl/goertzel_tone_gen_mac.sv
// rtl/goertzel_tone_gen_mac.sv - resonator step s0 = ((coef*s1)>>>frac) - s2; saturates when GTG_SAT_EN is defined
module gtg_mac
    import goertzel_pkg::*;
#(
    parameter int W   = GTG_W,
    parameter int C_W = GTG_C_W
) (
    input  logic signed [C_W-1:0] coef,
    input  logic signed [W-1:0]   s1,
    input  logic signed [W-1:0]   s2,
    output logic signed [W-1:0]   s0
);

`ifdef GTG_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    localparam int FRAC = q_frac(C_W);
    localparam int DW   = W + C_W + 1;

    localparam logic signed [DW-1:0] LIM_MAX = {{(C_W+2){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [DW-1:0] LIM_MIN = {{(C_W+2){1'b1}}, {(W-1){1'b0}}};

    logic signed [W+C_W-1:0] w_prod;
    logic signed [W+C_W-1:0] w_shift;
    logic signed [DW-1:0]    w_diff;

    assign w_prod  = coef * s1;
    // Floor division by 2^FRAC; the difference is kept wide enough never to overflow.
    assign w_shift = w_prod >>> FRAC;
    assign w_diff  = w_shift - s2;

    always_comb begin
        s0 = w_diff[W-1:0];
        if (SAT_EN && (w_diff > LIM_MAX)) begin
            s0 = LIM_MAX[W-1:0];
        end else if (SAT_EN && (w_diff < LIM_MIN)) begin
            s0 = LIM_MIN[W-1:0];
        end
    end

endmodule

// File: rtl/goertzel_tone_gen.sv
// rtl/goertzel_tone_gen.sv - recursive sinusoid generator (Goertzel resonator, no input); GTG_SAT_EN selects saturating state update
module goertzel_tone_gen
    import goertzel_pkg::*;
#(
    parameter int W   = GTG_W,
    parameter int C_W = GTG_C_W,
    parameter int L_W = GTG_L_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 start,
    input  logic signed [C_W-1:0] coef,
    input  logic signed [W-1:0]   init,
    input  logic [L_W-1:0]        len,
    output logic                 busy,
    output logic signed [W-1:0]   y,
    output logic                 y_valid,
    output logic                 done
);

    logic [1:0]            r_state;
    logic signed [C_W-1:0] r_coef;
    logic signed [W-1:0]   r_s1;
    logic signed [W-1:0]   r_s2;
    logic [L_W-1:0]        r_cnt;
    logic signed [W-1:0]   r_y;
    logic                  r_y_valid;
    logic                  r_done;
    logic                  r_busy;

    logic signed [W-1:0]   w_s0;
    logic                  w_accept;

    gtg_mac #(
        .W   (W),
        .C_W (C_W)
    ) u_mac (
        .coef (r_coef),
        .s1   (r_s1),
        .s2   (r_s2),
        .s0   (w_s0)
    );

    // busy stays high through the done cycle, so a start there is also refused.
    assign w_accept = (r_state == ST_IDLE) && !r_busy && start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_coef    <= '0;
            r_s1      <= '0;
            r_s2      <= '0;
            r_cnt     <= '0;
            r_y       <= '0;
            r_y_valid <= 1'b0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_y_valid <= 1'b0;
            r_done    <= 1'b0;
            if (w_accept) begin
                r_busy <= 1'b1;
            end else if (r_done) begin
                r_busy <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_coef  <= coef;
                        r_s1    <= init;
                        r_s2    <= '0;
                        r_cnt   <= len;
                        r_state <= (len == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (en) begin
                        r_y       <= r_s1;
                        r_y_valid <= 1'b1;
                        r_s2      <= r_s1;
                        r_s1      <= w_s0;
                        r_cnt     <= r_cnt - 1'b1;
                        if (r_cnt == L_W'(1)) begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign y       = r_y;
    assign y_valid = r_y_valid;
    assign done    = r_done;

endmodule

// File: tb/tb_goertzel_tone_gen.sv
// tb/tb_goertzel_tone_gen.sv - directed self-checking bench for goertzel_tone_gen
module tb_goertzel_tone_gen;
    import goertzel_pkg::*;

    localparam int W   = 24;
    localparam int C_W = 18;
    localparam int L_W = 16;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  en;
    logic                  start;
    logic signed [C_W-1:0] coef;
    logic signed [W-1:0]   init;
    logic [L_W-1:0]        len;
    logic                  busy;
    logic signed [W-1:0]   y;
    logic                  y_valid;
    logic                  done;

    int n_pass  = 0;
    int n_total = 0;

    logic signed [W-1:0] got[$];
    int cyc_last;
    int cyc_done;
    int cyc_idle;
    int n_done;
    int hold_bad;

    always #5 clk = ~clk;

    goertzel_tone_gen #(
        .W   (W),
        .C_W (C_W),
        .L_W (L_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .start   (start),
        .coef    (coef),
        .init    (init),
        .len     (len),
        .busy    (busy),
        .y       (y),
        .y_valid (y_valid),
        .done    (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_tone(input logic signed [C_W-1:0] c, input logic signed [W-1:0] s,
                              input logic [L_W-1:0] n);
        coef  = c;
        init  = s;
        len   = n;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // en high on cycles k % period == 0; start held high for the first start_cycles cycles.
    task automatic collect(input int period, input int budget, input int start_cycles);
        logic signed [W-1:0] prev_y;
        got.delete();
        cyc_last = -1;
        cyc_done = -1;
        cyc_idle = -1;
        n_done   = 0;
        hold_bad = 0;
        prev_y   = y;
        for (int k = 0; k < budget; k++) begin
            en    = ((k % period) == 0);
            start = (k < start_cycles);
            tick();
            if (y_valid) begin
                got.push_back(y);
                cyc_last = k;
            end else if (y !== prev_y) begin
                hold_bad++;
            end
            if (!en && y_valid) hold_bad++;
            prev_y = y;
            if (done) begin
                n_done++;
                if (cyc_done < 0) cyc_done = k;
            end
            if (!busy && cyc_idle < 0) cyc_idle = k;
        end
        en    = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_total++;
        if (y !== '0) $display("FAIL reset_y: got %0d, expected 0", y); else n_pass++;
        n_total++;
        if (y_valid !== 1'b0) $display("FAIL reset_y_valid: got %b, expected 0", y_valid); else n_pass++;
        n_total++;
        if (done !== 1'b0) $display("FAIL reset_done: got %b, expected 0", done); else n_pass++;
        n_total++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b, expected 0", busy); else n_pass++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_quarter_wave();
        int exp_y[6] = '{1000, 0, -1000, 0, 1000, 0};
        start_tone(18'sd0, 24'sd1000, 16'd6);
        n_total++;
        if (busy !== 1'b1) $display("FAIL qw_busy_after_start: got %b, expected 1", busy); else n_pass++;
        collect(1, 12, 0);
        n_total++;
        if (got.size() != 6) $display("FAIL qw_count: got %0d, expected 6", got.size()); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            n_total++;
            if (i >= got.size() || got[i] !== exp_y[i])
                $display("FAIL qw_y[%0d]: got %0d, expected %0d", i, (i < got.size()) ? got[i] : 'x, exp_y[i]);
            else n_pass++;
        end
        n_total++;
        if (cyc_done != cyc_last + 1) $display("FAIL qw_done_cycle: got %0d, expected %0d", cyc_done, cyc_last + 1); else n_pass++;
        n_total++;
        if (n_done != 1) $display("FAIL qw_done_pulses: got %0d, expected 1", n_done); else n_pass++;
        n_total++;
        if (cyc_idle != cyc_last + 2) $display("FAIL qw_busy_drop: got %0d, expected %0d", cyc_idle, cyc_last + 2); else n_pass++;
    endtask

    task automatic test_sixth_wave_gated();
        int exp_y[7] = '{1000, 1000, 0, -1000, -1000, 0, 1000};
        start_tone(18'sd65536, 24'sd1000, 16'd7);
        collect(2, 20, 0);
        n_total++;
        if (got.size() != 7) $display("FAIL sw_count: got %0d, expected 7", got.size()); else n_pass++;
        for (int i = 0; i < 7; i++) begin
            n_total++;
            if (i >= got.size() || got[i] !== exp_y[i])
                $display("FAIL sw_y[%0d]: got %0d, expected %0d", i, (i < got.size()) ? got[i] : 'x, exp_y[i]);
            else n_pass++;
        end
        n_total++;
        if (hold_bad != 0) $display("FAIL sw_hold_on_en_low: got %0d violations, expected 0", hold_bad); else n_pass++;
        n_total++;
        if (n_done != 1) $display("FAIL sw_done_pulses: got %0d, expected 1", n_done); else n_pass++;
    endtask

    task automatic test_overflow();
        int exp2;
`ifdef GTG_SAT_EN
        exp2 = int'(W_MAX);
`else
        exp2 = -7777216;
`endif
        start_tone(-18'sd131072, 24'sd3000000, 16'd3);
        collect(1, 8, 0);
        n_total++;
        if (got.size() != 3) $display("FAIL ov_count: got %0d, expected 3", got.size()); else n_pass++;
        n_total++;
        if (got.size() < 1 || got[0] !== 24'sd3000000) $display("FAIL ov_y0: got %0d, expected 3000000", (got.size() > 0) ? got[0] : 'x); else n_pass++;
        n_total++;
        if (got.size() < 2 || got[1] !== -24'sd6000000) $display("FAIL ov_y1: got %0d, expected -6000000", (got.size() > 1) ? got[1] : 'x); else n_pass++;
        n_total++;
        if (got.size() < 3 || got[2] !== exp2) $display("FAIL ov_y2: got %0d, expected %0d", (got.size() > 2) ? got[2] : 'x, exp2); else n_pass++;
    endtask

    task automatic test_zero_len();
        start_tone(18'sd0, 24'sd1000, 16'd0);
        n_total++;
        if (busy !== 1'b1) $display("FAIL zl_busy: got %b, expected 1", busy); else n_pass++;
        collect(1, 6, 0);
        n_total++;
        if (got.size() != 0) $display("FAIL zl_count: got %0d, expected 0", got.size()); else n_pass++;
        n_total++;
        if (cyc_done != 0) $display("FAIL zl_done_cycle: got %0d, expected 0", cyc_done); else n_pass++;
        n_total++;
        if (n_done != 1) $display("FAIL zl_done_pulses: got %0d, expected 1", n_done); else n_pass++;
        n_total++;
        if (cyc_idle != 1) $display("FAIL zl_busy_drop: got %0d, expected 1", cyc_idle); else n_pass++;
    endtask

    task automatic test_start_ignored();
        int exp_y[6] = '{1000, 0, -1000, 0, 1000, 0};
        start_tone(18'sd0, 24'sd1000, 16'd6);
        coef = 18'sd65536;
        init = 24'sd5;
        len  = 16'd2;
        collect(1, 6, 3);
        collect(1, 4, 0);
        n_total++;
        if (n_done != 1) $display("FAIL si_done_pulses: got %0d, expected 1", n_done); else n_pass++;
        n_total++;
        if (busy !== 1'b0) $display("FAIL si_busy_end: got %b, expected 0", busy); else n_pass++;
        start_tone(18'sd0, 24'sd1000, 16'd6);
        collect(1, 10, 0);
        n_total++;
        if (got.size() != 6) $display("FAIL si_count: got %0d, expected 6", got.size()); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            n_total++;
            if (i >= got.size() || got[i] !== exp_y[i])
                $display("FAIL si_y[%0d]: got %0d, expected %0d", i, (i < got.size()) ? got[i] : 'x, exp_y[i]);
            else n_pass++;
        end
    endtask

    task automatic test_ignored_start_in_run();
        int exp_y[6] = '{1000, 0, -1000, 0, 1000, 0};
        start_tone(18'sd0, 24'sd1000, 16'd6);
        coef = 18'sd65536;
        init = 24'sd7;
        len  = 16'd2;
        collect(1, 3, 3);
        collect(1, 8, 0);
        n_total++;
        if (got.size() != 3) $display("FAIL run_start_tail_count: got %0d, expected 3", got.size()); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            n_total++;
            if (i >= got.size() || got[i] !== exp_y[i + 3])
                $display("FAIL run_start_y[%0d]: got %0d, expected %0d", i + 3, (i < got.size()) ? got[i] : 'x, exp_y[i + 3]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_tone();
        int exp_y[6] = '{1000, 0, -1000, 0, 1000, 0};
        int done_seen;
        start_tone(18'sd0, 24'sd1000, 16'd6);
        collect(1, 3, 0);
        n_total++;
        if (got.size() != 3) $display("FAIL rm_pre_count: got %0d, expected 3", got.size()); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (y !== '0) $display("FAIL rm_y: got %0d, expected 0", y); else n_pass++;
        n_total++;
        if (busy !== 1'b0) $display("FAIL rm_busy: got %b, expected 0", busy); else n_pass++;
        done_seen = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (done) done_seen++;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (done) done_seen++;
        end
        n_total++;
        if (done_seen != 0) $display("FAIL rm_no_done: got %0d pulses, expected 0", done_seen); else n_pass++;
        start_tone(18'sd0, 24'sd1000, 16'd6);
        collect(1, 10, 0);
        n_total++;
        if (got.size() != 6) $display("FAIL rm_count: got %0d, expected 6", got.size()); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            n_total++;
            if (i >= got.size() || got[i] !== exp_y[i])
                $display("FAIL rm_y[%0d]: got %0d, expected %0d", i, (i < got.size()) ? got[i] : 'x, exp_y[i]);
            else n_pass++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        start = 1'b0;
        coef  = '0;
        init  = '0;
        len   = '0;
        test_reset();
        test_quarter_wave();
        test_sixth_wave_gated();
        test_overflow();
        test_zero_len();
        test_start_ignored();
        test_ignored_start_in_run();
        test_reset_mid_tone();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
